execute_mc: RTL and testbench
=============================

# execute_mc

Multi-cycle execute stage for the RISC-V-lite pipeline. It generalises the single-cycle EX stage in four ways: signed and unsigned branch compares on forwarded operands, an iterative radix-2 multiplier (optionally also a divider), an `ex_stall` request to the hazard unit, and bubble insertion into EX/MEM while a multi-cycle operation is in progress. It sits between the ID/EX and EX/MEM boundaries and owns the EX/MEM pipeline registers.

## Interface
Parameters:
- `N`, 32, datapath width; must be ≥ 8 and even.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `pipe_en` in 1: global pipeline advance enable from the hazard unit.
- `cwEX` in 13: control word.
  - [12] A-select: 0 = NPCin, 1 = r1.
  - [11] B-select: 0 = r2, 1 = Imm.
  - [10:8] branch code.
  - [7] jump enable.
  - [6:0] MEM/WB control, passed through.
- `aluOp` in 4: ALU operation, same encoding as `ALU`.
- `mdOp` in 3: 000 none, 001 MUL, 010 MULHU, 100 DIVU, 101 REMU, others none.
- `Rdest_in`, `NPCin`, `NPC4_IN`, `r1`, `r2`, `Imm` in N: ID/EX operands.
- `forwardA`, `forwardB` in 2: forwarding selects.
  - 00: mux output, 01: `MEMWBRdest`, 10: `EXMEMRdest`, 11: zero.
- `MEMWBRdest`, `EXMEMRdest` in N: forwarded values.
- `jPC` out N: combinational branch/jump target.
- `ex_stall` out 1: combinational; 1 requests that IF/ID/ID-EX hold.
- `ALUres`, `Bout`, `ImmOUT`, `NPC4_OUT`, `Rdest` out N: EX/MEM registers.
- `cwMEM` out 7, `PC_sel` out 1: EX/MEM registers.

## Operation
- Operand path:
  - `opA` = forwardA mux applied to (A-select mux).
  - `opB` = forwardB mux applied to (B-select mux).
  - Branch compares use the forwarded `r1` and `r2`: the forwardA/forwardB muxes applied to `r1` and `r2` directly, ignoring the A/B select.
- Branch codes:
  - 000 none, 001 BEQ, 010 BNE, 011 BLT (signed), 100 BGE (signed), 101 BLTU, 110 BGEU, 111 none.
- `jPC` = `NPCin` + (`Imm` << 1), N-bit wrap. `PC_sel` next value = jump enable OR branch taken.
- Non-md instruction (`mdOp` = none): single-cycle ALU path. EX/MEM loads ALU result, `opB`, `Imm`, `NPC4_IN`, cw[6:0], `PC_sel`, `Rdest_in`.
- md FSM: IDLE → BUSY → DONE → IDLE.
  - **IDLE**, valid md op present and `pipe_en` = 1:
    - Latch `opA`, `opB` and `mdOp` into internal registers.
    - Clear the counter.
    - `ex_stall` = 1; go to BUSY.
  - **BUSY**: one radix-2 iteration per cycle.
    - MUL/MULHU: shift-add into a 2N-bit accumulator.
    - DIVU/REMU: restoring, quotient and remainder N bits each.
    - `ex_stall` = 1. After N iterations go to DONE.
  - **DONE**: `ex_stall` = 0; result is muxed into the ALUres input.
    - MUL: low N bits. MULHU: high N bits. DIVU: quotient. REMU: remainder.
    - When `pipe_en` = 1, EX/MEM loads and the FSM returns to IDLE. Otherwise it stays in DONE with the result held.
- Bubble rule: while `ex_stall` = 1 and `pipe_en` = 1, EX/MEM loads a bubble: `cwMEM` = 0, `PC_sel` = 0, `Rdest` = 0, `ALUres` = 0.
- Divide by zero: quotient = all ones; remainder = dividend. No extra cycles.
- `pipe_en` = 0 in IDLE or BUSY: EX/MEM holds. BUSY iterations keep advancing; the operands are already latched.

## Timing
- Reset: every EX/MEM output is 0, the FSM is in IDLE, `ex_stall` = 0, and the counter and accumulators are 0.
- `rst` in BUSY or DONE aborts the operation. The next cycle is IDLE with no result written.
- Latency (pipe_en held at 1):
  - Single-cycle ops: result in EX/MEM 1 edge after issue.
  - md ops: `ex_stall` is high for N+1 cycles (issue cycle plus N BUSY cycles). The result appears in EX/MEM at the end of cycle N+1, so N+2 edges after issue.
- `jPC` and `ex_stall` are combinational. All other outputs are registered.
- Counter width: clog2(N)+1. DONE is entered when the counter reaches N−1 inside BUSY.

## Configuration
- `EXE_DIV_EN` defined: the DIVU/REMU datapath and remainder register are compiled in.
- `EXE_DIV_EN` undefined: `mdOp` 100 and 101 are treated as none. The ALU path executes as a single-cycle op with no stall, and the divider logic is absent.

## Test plan
- Reset: assert `rst` for 2 cycles mid-MUL → all outputs 0, `ex_stall` = 0, FSM in IDLE.
- ADD, `forwardA` = 10, `EXMEMRdest` = 5, `r2` = 3, B-select = 0 → `ALUres` = 8 after 1 edge.
- BLT, `r1` = 0xFFFFFFFF, `r2` = 1 → `PC_sel` = 1. BLTU with the same operands → `PC_sel` = 0. With `NPCin` = 0x100 and `Imm` = 4, `jPC` = 0x108.
- MUL 7 × 6 at N = 32 → `ex_stall` high for 33 cycles with bubbles in EX/MEM (`cwMEM` = 0), then `ALUres` = 42. Hold `pipe_en` = 0 for 3 cycles in DONE → result held, then loaded.
- MULHU 0xFFFFFFFF × 0xFFFFFFFF → `ALUres` = 0xFFFFFFFE.
- With `EXE_DIV_EN`:
  - REMU 100 / 7 → 2.
  - DIVU 100 / 0 → 0xFFFFFFFF.
  - REMU 100 / 0 → 100.
- Without `EXE_DIV_EN`: DIVU → no stall, single-cycle ALU result.

Source files
------------

// File: rtl/execute_mc.sv
// execute_mc: multi-cycle execute stage of the RISC-V-lite pipeline.
// Forwarded operand muxes, branch resolution, a single-cycle ALU and an
// iterative radix-2 multiplier. It owns the EX/MEM pipeline registers.
// Optional feature macro: EXE_DIV_EN adds the restoring divider (DIVU/REMU).
//
// ALU encoding (aluOp):
//   0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLL, 6 SRL, 7 SRA,
//   8 SLT, 9 SLTU, 10 pass B, others -> 0.
//
// Handshake with the hazard unit: EX/MEM advances on an edge where
// pipe_en = 1. ex_stall = 1 asks IF/ID/ID-EX to hold their contents; EX/MEM
// then takes a bubble on every pipe_en edge until the md result is ready.
// An instruction leaves EX on an edge with pipe_en = 1 and ex_stall = 0.
module execute_mc #(
    parameter int N = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         pipe_en,
    input  logic [12:0]  cwEX,
    input  logic [3:0]   aluOp,
    input  logic [2:0]   mdOp,
    input  logic [N-1:0] Rdest_in,
    input  logic [N-1:0] NPCin,
    input  logic [N-1:0] NPC4_IN,
    input  logic [N-1:0] r1,
    input  logic [N-1:0] r2,
    input  logic [N-1:0] Imm,
    input  logic [1:0]   forwardA,
    input  logic [1:0]   forwardB,
    input  logic [N-1:0] MEMWBRdest,
    input  logic [N-1:0] EXMEMRdest,
    output logic [N-1:0] jPC,
    output logic         ex_stall,
    output logic [N-1:0] ALUres,
    output logic [N-1:0] Bout,
    output logic [N-1:0] ImmOUT,
    output logic [N-1:0] NPC4_OUT,
    output logic [N-1:0] Rdest,
    output logic [6:0]   cwMEM,
    output logic         PC_sel,
    output logic [1:0]   dbg_state
);
    localparam int CW = $clog2(N) + 1;
    localparam int SW = $clog2(N);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } md_state_t;

    md_state_t state, state_nxt;

    logic [N-1:0]   a_base, b_base, op_a, op_b, r1_fwd, r2_fwd;
    logic [N-1:0]   alu_res, md_res, alu_in;
    logic [SW-1:0]  shamt;
    logic           md_valid, taken, pc_sel_nxt, in_done;
    logic [2*N-1:0] acc;
    logic [N-1:0]   mcand;
    logic [2:0]     md_q;
    logic [CW-1:0]  cnt;
    logic [N:0]     mul_sum;
`ifdef EXE_DIV_EN
    logic [N-1:0]   rem;
    logic [N:0]     div_shift, div_diff;
    logic           md_is_div;
`endif

    function automatic logic [N-1:0] fwd_mux(input logic [1:0] sel, input logic [N-1:0] base,
                                             input logic [N-1:0] mw, input logic [N-1:0] em);
        case (sel)
            2'b00:   return base;
            2'b01:   return mw;
            2'b10:   return em;
            default: return '0;
        endcase
    endfunction

    // Decode which mdOp codes start a multi-cycle operation in this build
    always_comb begin
        md_valid = 1'b0;
        case (mdOp)
            3'b001, 3'b010: md_valid = 1'b1;
`ifdef EXE_DIV_EN
            3'b100, 3'b101: md_valid = 1'b1;
`endif
            default:        md_valid = 1'b0;
        endcase
    end

    // Operand selection followed by forwarding; branches see forwarded r1/r2
    always_comb begin
        a_base = cwEX[12] ? r1 : NPCin;
        b_base = cwEX[11] ? Imm : r2;
        op_a   = fwd_mux(forwardA, a_base, MEMWBRdest, EXMEMRdest);
        op_b   = fwd_mux(forwardB, b_base, MEMWBRdest, EXMEMRdest);
        r1_fwd = fwd_mux(forwardA, r1, MEMWBRdest, EXMEMRdest);
        r2_fwd = fwd_mux(forwardB, r2, MEMWBRdest, EXMEMRdest);
    end

    assign shamt = op_b[SW-1:0];

    // Single-cycle ALU
    always_comb begin
        alu_res = '0;
        case (aluOp)
            4'd0:    alu_res = op_a + op_b;
            4'd1:    alu_res = op_a - op_b;
            4'd2:    alu_res = op_a & op_b;
            4'd3:    alu_res = op_a | op_b;
            4'd4:    alu_res = op_a ^ op_b;
            4'd5:    alu_res = op_a << shamt;
            4'd6:    alu_res = op_a >> shamt;
            4'd7:    alu_res = $signed(op_a) >>> shamt;
            4'd8:    alu_res = {{(N-1){1'b0}}, $signed(op_a) < $signed(op_b)};
            4'd9:    alu_res = {{(N-1){1'b0}}, op_a < op_b};
            4'd10:   alu_res = op_b;
            default: alu_res = '0;
        endcase
    end

    // Branch resolution on forwarded register operands
    always_comb begin
        taken = 1'b0;
        case (cwEX[10:8])
            3'b001:  taken = (r1_fwd == r2_fwd);
            3'b010:  taken = (r1_fwd != r2_fwd);
            3'b011:  taken = ($signed(r1_fwd) < $signed(r2_fwd));
            3'b100:  taken = ($signed(r1_fwd) >= $signed(r2_fwd));
            3'b101:  taken = (r1_fwd < r2_fwd);
            3'b110:  taken = (r1_fwd >= r2_fwd);
            default: taken = 1'b0;
        endcase
    end

    assign pc_sel_nxt = cwEX[7] | taken;
    assign jPC        = NPCin + (Imm << 1);

    // md FSM state register
    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    // md FSM next-state logic; BUSY runs regardless of pipe_en
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (md_valid && pipe_en) state_nxt = S_BUSY;
            S_BUSY:  if (cnt == CW'(N - 1)) state_nxt = S_DONE;
            S_DONE:  if (pipe_en) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // md FSM outputs: stall while issuing or iterating, result select in DONE
    always_comb begin
        ex_stall  = 1'b0;
        in_done   = 1'b0;
        dbg_state = state;
        case (state)
            S_IDLE:  ex_stall = md_valid;
            S_BUSY:  ex_stall = 1'b1;
            S_DONE:  in_done  = 1'b1;
            default: ex_stall = 1'b0;
        endcase
    end

    // One shift-add step: add the multiplicand into the high half when the
    // current multiplier bit is set, then shift the whole accumulator right.
    assign mul_sum = {1'b0, acc[2*N-1:N]} + (acc[0] ? {1'b0, mcand} : {(N+1){1'b0}});

`ifdef EXE_DIV_EN
    // One restoring step: bring the next dividend bit into the remainder and
    // keep the subtraction only when it does not go negative. A zero divisor
    // never goes negative, giving an all-ones quotient and rem = dividend.
    assign md_is_div = md_q[2];
    assign div_shift = {rem, acc[N-1]};
    assign div_diff  = div_shift - {1'b0, mcand};
`endif

    // Multi-cycle datapath: latch operands on issue, iterate in BUSY
    always_ff @(posedge clk) begin
        if (rst) begin
            acc   <= '0;
            mcand <= '0;
            md_q  <= '0;
            cnt   <= '0;
`ifdef EXE_DIV_EN
            rem   <= '0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    if (md_valid && pipe_en) begin
                        acc   <= {{N{1'b0}}, op_a};
                        mcand <= op_b;
                        md_q  <= mdOp;
                        cnt   <= '0;
`ifdef EXE_DIV_EN
                        rem   <= '0;
`endif
                    end
                end
                S_BUSY: begin
                    cnt <= cnt + CW'(1);
`ifdef EXE_DIV_EN
                    if (md_is_div) begin
                        if (!div_diff[N]) begin
                            rem          <= div_diff[N-1:0];
                            acc[N-1:0]   <= {acc[N-2:0], 1'b1};
                        end else begin
                            rem          <= div_shift[N-1:0];
                            acc[N-1:0]   <= {acc[N-2:0], 1'b0};
                        end
                    end else begin
                        acc <= {mul_sum, acc[N-1:1]};
                    end
`else
                    acc <= {mul_sum, acc[N-1:1]};
`endif
                end
                default: ;
            endcase
        end
    end

    // Final md result selection
    always_comb begin
        md_res = acc[N-1:0];
        case (md_q)
            3'b010:  md_res = acc[2*N-1:N];
`ifdef EXE_DIV_EN
            3'b101:  md_res = rem;
`endif
            default: md_res = acc[N-1:0];
        endcase
    end

    assign alu_in = in_done ? md_res : alu_res;

    // EX/MEM registers: bubble while stalling, normal load otherwise
    always_ff @(posedge clk) begin
        if (rst) begin
            ALUres   <= '0;
            Bout     <= '0;
            ImmOUT   <= '0;
            NPC4_OUT <= '0;
            Rdest    <= '0;
            cwMEM    <= '0;
            PC_sel   <= 1'b0;
        end else if (pipe_en) begin
            Bout     <= op_b;
            ImmOUT   <= Imm;
            NPC4_OUT <= NPC4_IN;
            if (ex_stall) begin
                ALUres <= '0;
                Rdest  <= '0;
                cwMEM  <= '0;
                PC_sel <= 1'b0;
            end else begin
                ALUres <= alu_in;
                Rdest  <= Rdest_in;
                cwMEM  <= cwEX[6:0];
                PC_sel <= pc_sel_nxt;
            end
        end
    end

endmodule

// File: tb/tb_execute_mc.sv
// tb_execute_mc: randomized and directed bench for execute_mc with a
// reference model and an expected-result queue drained by a monitor.
module tb_execute_mc;
    localparam int N = 32;

    typedef struct {
        logic [12:0]  cw;
        logic [3:0]   alu_op;
        logic [2:0]   md_op;
        logic [N-1:0] rdest, npc, npc4, r1, r2, imm, memwb, exmem;
        logic [1:0]   fa, fb;
    } instr_t;

    typedef struct packed {
        logic [N-1:0] alu;
        logic [N-1:0] bout;
        logic [N-1:0] imm;
        logic [N-1:0] npc4;
        logic [N-1:0] rdest;
        logic [6:0]   cw;
        logic         pc_sel;
    } exp_t;

    localparam int EXP_W = $bits(exp_t);

    // clock / reset and DUT signals
    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         pipe_en = 1'b0;
    logic [12:0]  cwEX = '0;
    logic [3:0]   aluOp = '0;
    logic [2:0]   mdOp = '0;
    logic [N-1:0] Rdest_in = '0, NPCin = '0, NPC4_IN = '0, r1 = '0, r2 = '0, Imm = '0;
    logic [1:0]   forwardA = '0, forwardB = '0;
    logic [N-1:0] MEMWBRdest = '0, EXMEMRdest = '0;
    logic [N-1:0] jPC, ALUres, Bout, ImmOUT, NPC4_OUT, Rdest;
    logic         ex_stall, PC_sel;
    logic [6:0]   cwMEM;
    logic [1:0]   dbg_state;

    always #5 clk = ~clk;

    execute_mc #(.N(N)) dut (
        .clk(clk), .rst(rst), .pipe_en(pipe_en), .cwEX(cwEX), .aluOp(aluOp), .mdOp(mdOp),
        .Rdest_in(Rdest_in), .NPCin(NPCin), .NPC4_IN(NPC4_IN), .r1(r1), .r2(r2), .Imm(Imm),
        .forwardA(forwardA), .forwardB(forwardB), .MEMWBRdest(MEMWBRdest),
        .EXMEMRdest(EXMEMRdest), .jPC(jPC), .ex_stall(ex_stall), .ALUres(ALUres),
        .Bout(Bout), .ImmOUT(ImmOUT), .NPC4_OUT(NPC4_OUT), .Rdest(Rdest), .cwMEM(cwMEM),
        .PC_sel(PC_sel), .dbg_state(dbg_state)
    );

    int total = 0;
    int bad   = 0;
    logic [EXP_W-1:0] exp_q[$];

    task automatic chk(input string name, input logic [N-1:0] got, input logic [N-1:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got=%h want=%h at %0t", name, got, want, $time);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic is_md(input logic [2:0] op);
`ifdef EXE_DIV_EN
        return (op == 3'b001) || (op == 3'b010) || (op == 3'b100) || (op == 3'b101);
`else
        return (op == 3'b001) || (op == 3'b010);
`endif
    endfunction

    function automatic logic [N-1:0] fwd(input logic [1:0] s, input logic [N-1:0] v,
                                         input logic [N-1:0] mw, input logic [N-1:0] em);
        if (s == 2'd1) return mw;
        if (s == 2'd2) return em;
        if (s == 2'd3) return '0;
        return v;
    endfunction

    function automatic logic [N-1:0] alu_model(input logic [3:0] op, input logic [N-1:0] a,
                                               input logic [N-1:0] b);
        int unsigned sh;
        sh = b % N;
        case (op)
            4'd0:  return a + b;
            4'd1:  return a - b;
            4'd2:  return a & b;
            4'd3:  return a | b;
            4'd4:  return a ^ b;
            4'd5:  return a << sh;
            4'd6:  return a >> sh;
            4'd7:  return $signed(a) >>> sh;
            4'd8:  return ($signed(a) < $signed(b)) ? N'(1) : N'(0);
            4'd9:  return (a < b) ? N'(1) : N'(0);
            4'd10: return b;
            default: return '0;
        endcase
    endfunction

    function automatic logic [N-1:0] jpc_model(input instr_t t);
        return t.npc + (t.imm << 1);
    endfunction

    function automatic exp_t model(input instr_t t);
        exp_t e;
        logic [N-1:0] a, b, x, y, res;
        logic [2*N-1:0] p;
        logic tk;
        a = fwd(t.fa, t.cw[12] ? t.r1 : t.npc, t.memwb, t.exmem);
        b = fwd(t.fb, t.cw[11] ? t.imm : t.r2, t.memwb, t.exmem);
        x = fwd(t.fa, t.r1, t.memwb, t.exmem);
        y = fwd(t.fb, t.r2, t.memwb, t.exmem);
        case (t.cw[10:8])
            3'd1: tk = (x == y);
            3'd2: tk = (x != y);
            3'd3: tk = ($signed(x) < $signed(y));
            3'd4: tk = ($signed(x) >= $signed(y));
            3'd5: tk = (x < y);
            3'd6: tk = (x >= y);
            default: tk = 1'b0;
        endcase
        p = {{N{1'b0}}, a} * {{N{1'b0}}, b};
        if (is_md(t.md_op)) begin
            case (t.md_op)
                3'b001:  res = p[N-1:0];
                3'b010:  res = p[2*N-1:N];
                3'b100:  res = (b == 0) ? {N{1'b1}} : a / b;
                default: res = (b == 0) ? a : a % b;
            endcase
        end else begin
            res = alu_model(t.alu_op, a, b);
        end
        e.alu    = res;
        e.bout   = b;
        e.imm    = t.imm;
        e.npc4   = t.npc4;
        e.rdest  = t.rdest;
        e.cw     = t.cw[6:0];
        e.pc_sel = t.cw[7] | tk;
        return e;
    endfunction

    // ---------------- driver ----------------
    task automatic drive(input instr_t t);
        cwEX = t.cw; aluOp = t.alu_op; mdOp = t.md_op; Rdest_in = t.rdest;
        NPCin = t.npc; NPC4_IN = t.npc4; r1 = t.r1; r2 = t.r2; Imm = t.imm;
        forwardA = t.fa; forwardB = t.fb; MEMWBRdest = t.memwb; EXMEMRdest = t.exmem;
    endtask

    function automatic logic [N-1:0] rv();
        if ($urandom_range(0, 3) == 0) return N'($urandom_range(0, 15));
        return N'($urandom);
    endfunction

    function automatic instr_t rand_instr();
        instr_t t;
        t.cw = 13'($urandom);
        t.alu_op = 4'($urandom_range(0, 11));
        case ($urandom_range(0, 11))
            0:       t.md_op = 3'b001;
            1:       t.md_op = 3'b010;
            2:       t.md_op = 3'b100;
            3:       t.md_op = 3'b101;
            4:       t.md_op = 3'($urandom);
            default: t.md_op = 3'b000;
        endcase
        t.rdest = rv(); t.npc = rv(); t.npc4 = rv(); t.r1 = rv(); t.r2 = rv();
        t.imm = rv(); t.memwb = rv(); t.exmem = rv();
        t.fa = 2'($urandom); t.fb = 2'($urandom);
        return t;
    endfunction

    function automatic instr_t blank();
        instr_t t;
        t.cw = '0; t.alu_op = '0; t.md_op = '0; t.rdest = '0; t.npc = '0; t.npc4 = '0;
        t.r1 = '0; t.r2 = '0; t.imm = '0; t.memwb = '0; t.exmem = '0; t.fa = '0; t.fb = '0;
        return t;
    endfunction

    // Present one instruction until it leaves EX. mode 0: random pipe_en,
    // 1: pipe_en always high, 2: high but held low for 3 cycles once the
    // stall has dropped. Entered and left just after a rising edge.
    task automatic issue(input instr_t t, input exp_t e, input int mode);
        int stalls, cyc, holds;
        logic done;
        drive(t);
        exp_q.push_back(e);
        stalls = 0; cyc = 0; holds = 3; done = 1'b0;
        while (!done && cyc < 400) begin
            if (mode == 0 && !(is_md(t.md_op) && cyc == 0))
                pipe_en = ($urandom_range(0, 3) != 0);
            else
                pipe_en = 1'b1;
            #1;
            if (mode == 2 && !ex_stall && holds > 0) begin
                pipe_en = 1'b0;
                holds--;
            end
            chk("jpc", jPC, jpc_model(t));
            if (ex_stall) stalls++;
            done = pipe_en && !ex_stall;
            @(posedge clk);
            #1;
            cyc++;
        end
        chk("issue_completes", N'(done), N'(1));
        chk("stall_cycles", N'(stalls), is_md(t.md_op) ? N'(N + 1) : N'(0));
    endtask

    // ---------------- monitor / scoreboard ----------------
    // act: what the last rising edge did to EX/MEM (0 reset, 1 hold, 2 bubble, 3 load)
    exp_t cur = '0;
    logic extra_known = 1'b1;
    int   act = 0;

    always @(negedge clk) begin
        case (act)
            0: begin cur = '0; extra_known = 1'b1; end
            2: begin
                cur.alu = '0; cur.cw = '0; cur.pc_sel = 1'b0; cur.rdest = '0;
                extra_known = 1'b0;
            end
            3: begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL load_with_expect: got=unexpected load want=none at %0t", $time);
                end else begin
                    cur = exp_t'(exp_q.pop_front());
                    extra_known = 1'b1;
                end
            end
            default: ;
        endcase
        chk("alures", ALUres, cur.alu);
        chk("cwmem", N'(cwMEM), N'(cur.cw));
        chk("pc_sel", N'(PC_sel), N'(cur.pc_sel));
        chk("rdest", Rdest, cur.rdest);
        if (extra_known) begin
            chk("bout", Bout, cur.bout);
            chk("immout", ImmOUT, cur.imm);
            chk("npc4", NPC4_OUT, cur.npc4);
        end
        if (rst)           act = 0;
        else if (!pipe_en) act = 1;
        else if (ex_stall) act = 2;
        else               act = 3;
    end

    // ---------------- stimulus ----------------
    initial begin
        instr_t t;
        exp_t e;
        drive(blank());
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("reset_stall", N'(ex_stall), N'(0));
        chk("reset_state", N'(dbg_state), N'(0));

        // ADD with EX/MEM forwarding on A
        t = blank(); t.cw = 13'h0015; t.alu_op = 4'd0; t.fa = 2'b10; t.exmem = 5; t.r2 = 3;
        t.rdest = 9;
        e = model(t); e.alu = 8;
        issue(t, e, 1);

        // BLT / BLTU with the same operands
        t = blank(); t.cw = {1'b1, 1'b0, 3'b011, 1'b0, 7'h11}; t.r1 = 32'hFFFF_FFFF; t.r2 = 1;
        t.npc = 32'h100; t.imm = 4;
        chk("jpc_directed", jpc_model(t), 32'h108);
        drive(t); #1;
        chk("jpc_directed_dut", jPC, 32'h108);
        e = model(t); e.pc_sel = 1'b1;
        issue(t, e, 1);
        t.cw[10:8] = 3'b101;
        e = model(t); e.pc_sel = 1'b0;
        issue(t, e, 1);

        // MUL 7 x 6 with a 3-cycle hold in DONE
        t = blank(); t.cw = {1'b1, 1'b0, 3'b000, 1'b0, 7'h55}; t.md_op = 3'b001;
        t.r1 = 7; t.r2 = 6; t.rdest = 3;
        e = model(t); e.alu = 42;
        issue(t, e, 2);

        // MULHU all-ones squared
        t.md_op = 3'b010; t.r1 = 32'hFFFF_FFFF; t.r2 = 32'hFFFF_FFFF;
        e = model(t); e.alu = 32'hFFFF_FFFE;
        issue(t, e, 1);

`ifdef EXE_DIV_EN
        t.md_op = 3'b101; t.r1 = 100; t.r2 = 7;
        e = model(t); e.alu = 2;
        issue(t, e, 1);
        t.md_op = 3'b100; t.r2 = 0;
        e = model(t); e.alu = 32'hFFFF_FFFF;
        issue(t, e, 1);
        t.md_op = 3'b101;
        e = model(t); e.alu = 100;
        issue(t, e, 1);
`else
        // DIVU falls back to the single-cycle ALU (ADD) with no stall
        t.md_op = 3'b100; t.alu_op = 4'd0; t.r1 = 100; t.r2 = 7;
        e = model(t); e.alu = 107;
        issue(t, e, 1);
`endif

        // Reset in the middle of a MUL: no result, back to IDLE
        t = blank(); t.cw = {1'b1, 1'b0, 3'b000, 1'b0, 7'h7F}; t.md_op = 3'b001;
        t.r1 = 9; t.r2 = 9; t.rdest = 4;
        drive(t);
        pipe_en = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        rst = 1'b1; pipe_en = 1'b0;
        drive(blank());
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("midmul_reset_stall", N'(ex_stall), N'(0));
        chk("midmul_reset_state", N'(dbg_state), N'(0));
        chk("midmul_reset_alu", ALUres, '0);

        // Random traffic
        for (int i = 0; i < 150; i++) begin
            t = rand_instr();
            issue(t, model(t), 0);
        end

        @(negedge clk);
        #1;
        chk("queue_drained", N'(exp_q.size()), N'(0));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
